// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;

  typedef logic [3:0] rnd_idx_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } key_state_e;

  function automatic logic [7:0] rcon(input rnd_idx_t r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] sbout
);
  import aes_pkg::*;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] a;
  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 == a^-1 (and maps 0 to 0): product of a^2, a^4 .. a^128.
  always_comb begin
    a   = {x, y};
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sbout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
module aes_subword (
  input  logic [31:0] word,
  output logic [31:0] subbed
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x     (word[8*i+7 -: 4]),
      .y     (word[8*i+3 -: 4]),
      .sbout (subbed[8*i+7 -: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry bank
// with a random-access read port for the inverse cipher.
module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             rk_valid,
  output logic [3:0]       rk_idx,
  output logic [KEY_W-1:0] rk_out,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);
  import aes_pkg::*;

  localparam rnd_idx_t LastRnd = rnd_idx_t'(NUM_ROUNDS);

  key_state_e       state_q, state_d;
  rnd_idx_t         rnd_q, rnd_d;
  logic [KEY_W-1:0] work_q, work_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  rnd_idx_t         rk_idx_q, rk_idx_d;
  logic             rk_valid_q, rk_valid_d;
  logic             done_q, done_d;

  logic [KEY_W-1:0] bank_q [0:NUM_ROUNDS];
  logic             bank_we;
  rnd_idx_t         bank_waddr;
  logic [KEY_W-1:0] bank_wdata;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, temp;
  logic [31:0] n0, n1, n2, n3;
  logic [KEY_W-1:0] next_key;

  assign w0 = work_q[127:96];
  assign w1 = work_q[95:64];
  assign w2 = work_q[63:32];
  assign w3 = work_q[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_subword u_subword (
    .word   (rot_w3),
    .subbed (sub_w3)
  );

  assign temp     = sub_w3 ^ {rcon(rnd_q), 24'h000000};
  assign n0       = w0 ^ temp;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    work_d     = work_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = done_q;
    bank_we    = 1'b0;
    bank_waddr = rnd_q;
    bank_wdata = next_key;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          rnd_d      = 4'd1;
          work_d     = key_in;
          rk_out_d   = key_in;
          rk_idx_d   = 4'd0;
          rk_valid_d = 1'b1;
          done_d     = 1'b0;
          bank_we    = 1'b1;
          bank_waddr = 4'd0;
          bank_wdata = key_in;
        end
      end
      StRun: begin
        work_d     = next_key;
        rk_out_d   = next_key;
        rk_idx_d   = rnd_q;
        rk_valid_d = 1'b1;
        bank_we    = 1'b1;
        if (rnd_q == LastRnd) begin
          state_d = StIdle;
          rnd_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rnd_q      <= '0;
      work_q     <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      work_q     <= work_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[bank_waddr] <= bank_wdata;
    end
  end

  // Same-cycle writes are not forwarded: the read sees the registered entry.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= LastRnd) rd_key = bank_q[rd_idx];
  end

  assign busy     = (state_q == StRun);
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_out   = rk_out_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;

  localparam logic [127:0] FipsKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsRk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroKey  = 128'h0;
  localparam logic [127:0] ZeroRk1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroRk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_idx = '0;
  logic         busy, done, rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out, rd_key;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         chk;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   pulse_cnt = 0;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: every rk_valid pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rk_valid) begin
      exp_t e;
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: got rk_valid idx %0d, expected no output", rk_idx);
      end else begin
        e = sb_q.pop_front();
        check_int("rk_idx", int'(rk_idx), int'(e.idx));
        if (e.chk) check128($sformatf("rk_out idx%0d", e.idx), rk_out, e.key);
      end
    end
  end

  task automatic push_run(input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k10);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx = 4'(i);
      e.key = (i == 0) ? k0 : (i == 1) ? k1 : k10;
      e.chk = (i <= 1) || (i == 10);
      sb_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    step();
    start  = 1'b0;
  endtask

  // Counts edges from T0 until done rises, bounded; also flags an early busy drop.
  task automatic wait_done(input string name, input int n0, output logic busy_drop);
    int n;
    n = n0;
    busy_drop = 1'b0;
    while (!done && n < 20) begin
      if (!busy) busy_drop = 1'b1;
      step();
      n++;
    end
    check_int(name, n, 10);
  endtask

  task automatic read_chk(input string name, input logic [3:0] idx, input logic [127:0] req);
    rd_idx = idx;
    #1;
    check128(name, rd_key, req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic drop;

    // Reset state
    #1;
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);
    check_int("reset rk_valid", int'(rk_valid), 0);
    check_int("reset rk_idx", int'(rk_idx), 0);
    check128("reset rk_out", rk_out, '0);
    read_chk("reset rd_key0", 4'd0, '0);
    #20 rst_n = 1'b1;
    step();

    // FIPS-197 key, single start pulse
    pulse_cnt = 0;
    push_run(FipsKey, FipsRk1, FipsRk10);
    run_start(FipsKey);
    check_int("t1 busy after T0", int'(busy), 1);
    check_int("t1 done after T0", int'(done), 0);
    wait_done("t1 done latency", 0, drop);
    check_int("t1 busy after done", int'(busy), 0);
    step();
    step();
    check_int("t1 rk_valid pulses", pulse_cnt, 11);
    read_chk("t1 rd_key10", 4'd10, FipsRk10);
    read_chk("t1 rd_key0", 4'd0, FipsKey);
    read_chk("t1 rd_key1", 4'd1, FipsRk1);

    // Second start mid-run with a different key is ignored
    pulse_cnt = 0;
    push_run(FipsKey, FipsRk1, FipsRk10);
    run_start(FipsKey);
    key_in = ZeroKey;
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("t3 done latency", 4, drop);
    check_int("t3 busy stayed high", int'(drop), 0);
    step();
    step();
    check_int("t3 rk_valid pulses", pulse_cnt, 11);
    read_chk("t3 rd_key10", 4'd10, FipsRk10);

    // Asynchronous reset mid-expansion
    push_run(FipsKey, FipsRk1, FipsRk10);
    run_start(FipsKey);
    step();
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_int("t4 busy in reset", int'(busy), 0);
    check_int("t4 done in reset", int'(done), 0);
    check_int("t4 rk_valid in reset", int'(rk_valid), 0);
    check_int("t4 rk_idx in reset", int'(rk_idx), 0);
    check128("t4 rk_out in reset", rk_out, '0);
    for (int i = 0; i < 16; i++) read_chk($sformatf("t4 rd_key%0d in reset", i), 4'(i), '0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check_int("t4 idle after release", int'(busy), 0);
    push_run(FipsKey, FipsRk1, FipsRk10);
    run_start(FipsKey);
    wait_done("t4 done latency", 0, drop);
    read_chk("t4 rd_key10", 4'd10, FipsRk10);

    // Back-to-back: zero-key start in the cycle done rises
    push_run(ZeroKey, ZeroRk1, ZeroRk10);
    run_start(ZeroKey);
    check_int("t5 done drops at T0", int'(done), 0);
    wait_done("t5 done latency", 0, drop);
    step();
    read_chk("t5 rd_key0", 4'd0, ZeroKey);
    read_chk("t5 rd_key1", 4'd1, ZeroRk1);
    read_chk("t5 rd_key10", 4'd10, ZeroRk10);
    for (int i = 11; i < 16; i++) read_chk($sformatf("t5 rd_key%0d", i), 4'(i), '0);

    step();
    step();
    check_int("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
